ok_block_pipe_out_fifo: RTL

OK_BLOCK_PIPE_OUT_FIFO -- requirements
Module: ok_block_pipe_out_fifo

---
 rtl/ok_block_pipe_out_fifo.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ok_block_pipe_out_fifo.sv
//------------------------------------------------------------------------------
// Module  : ok_block_pipe_out_fifo
// Brief   : FWFT FIFO that releases its contents to a host in fixed-size blocks
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ok_block_pipe_out_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                          ti_clk,
    input  logic                          ti_reset,
    input  logic [7:0]                    ep_addr,
    input  logic [7:0]                    ti_addr,
    input  logic                          ti_read,
    input  logic                          ti_blockstart,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ep_ready,
    output logic                          ep_read,
    output logic [DATA_WIDTH-1:0]         ep_dataout,
    output logic                          block_done,
    output logic                          underrun,
    output logic                          overflow
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam bit c_PARAMS_OK = (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0)
                               && (BLOCK_SIZE >= 1) && (BLOCK_SIZE <= FIFO_DEPTH);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_LW-1:0]       r_level;
    logic [c_LW-1:0]       r_burst_cnt;
    logic [0:0]            r_state;
    logic [0:0]            w_next_state;
    logic                  r_block_done;
    logic                  r_underrun;
    logic                  r_overflow;

    logic w_sel;
    logic w_empty;
    logic w_full;
    logic w_ready;
    logic w_pop;
    logic w_push;
    logic w_last;
    logic w_underrun_set;
    logic w_overflow_set;

    assign w_sel   = (ti_addr == ep_addr);
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_LW'(FIFO_DEPTH));

    // State register
    always_ff @(posedge ti_clk) begin
        if (ti_reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (ti_blockstart && w_ready) begin
                    w_next_state = c_BURST;
                end
            end
            c_BURST: begin
                if (w_pop && w_last) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output / datapath-control logic
    always_comb begin
        w_ready        = w_sel && (r_state == c_IDLE) && (r_level >= c_LW'(BLOCK_SIZE));
        w_pop          = 1'b0;
        w_underrun_set = 1'b0;
        w_last         = (r_burst_cnt == c_LW'(BLOCK_SIZE - 1));
        if (w_sel && ti_read) begin
            if (r_state == c_BURST && !w_empty) begin
                w_pop = 1'b1;
            end else begin
                w_underrun_set = 1'b1;
            end
        end
        // A pop frees a slot in the same cycle, so a write to a full FIFO is accepted then
        w_push         = wr_en && (!w_full || w_pop);
        w_overflow_set = wr_en && !w_push;
    end

    always_ff @(posedge ti_clk) begin
        if (w_push && !ti_reset) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge ti_clk) begin
        if (ti_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_burst_cnt  <= '0;
            r_block_done <= 1'b0;
            r_underrun   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
            if (r_state == c_IDLE && ti_blockstart && w_ready) begin
                r_burst_cnt <= '0;
            end else if (w_pop) begin
                r_burst_cnt <= r_burst_cnt + c_LW'(1);
            end
            r_block_done <= w_pop && w_last;
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign full       = w_full;
    assign level      = r_level;
    assign ep_ready   = w_ready;
    assign ep_read    = w_pop;
    assign ep_dataout = (w_sel && !w_empty) ? r_mem[r_rd_ptr] : '0;
    assign block_done = r_block_done;
    assign underrun   = r_underrun;
    assign overflow   = r_overflow;

    // Configuration guard: bad parameters or an endpoint address outside the pipe-out range
    a_config_ok: assert property (@(posedge ti_clk) disable iff (ti_reset)
        c_PARAMS_OK && (ep_addr >= 8'hA0) && (ep_addr <= 8'hBF))
    else begin
        $error("ok_block_pipe_out_fifo: illegal configuration (ep_addr=%h)", ep_addr);
        $finish;
    end

endmodule

`default_nettype wire
